// File: rtl/fir_tap_line_if.sv
// Handshake bundle between the sample source, the tap line and the FIR multiplier stage.
interface fir_tap_line_if #(
   parameter int WIDTH = 16,
   parameter int TAPS  = 6,
   parameter int CNT_W = 16
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      in_data;
   logic                  win_valid;
   logic                  win_ready;
   logic [TAPS*WIDTH-1:0] win_data;
   logic [CNT_W-1:0]      win_cnt;

   modport master (
      output in_valid, in_data, win_ready,
      input  in_ready, win_valid, win_data, win_cnt
   );

   modport slave (
      input  in_valid, in_data, win_ready,
      output in_ready, win_valid, win_data, win_cnt
   );
endinterface

// File: rtl/fir_tap_line.sv
// Sliding window of TAPS consecutive samples feeding the FIR multipliers; slot 0 is newest.
// Optional FIR_TAP_ZERO_PRIME_EN: present a window after every accept, unwritten history reading as zero.
module fir_tap_line #(
   parameter int WIDTH = 16,
   parameter int TAPS  = 6,
   parameter int CNT_W = 16
) (
   input logic            clk,
   input logic            rst,
   input logic            flush,
   fir_tap_line_if.slave  bus
);
   logic signed [WIDTH-1:0] slot_p1 [TAPS];
   logic                    win_valid_p1;
   logic [CNT_W-1:0]        cnt_p1;
   logic                    accept;
   logic                    consume;
   logic                    window_ready;

   assign bus.in_ready = !rst && !flush && (!win_valid_p1 || bus.win_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign consume      = win_valid_p1 && bus.win_ready;

`ifdef FIR_TAP_ZERO_PRIME_EN
   assign window_ready = accept;
`else
   localparam int FILL_W = $clog2(TAPS + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TAPS);

   logic [FILL_W-1:0] fill_p1;
   logic [FILL_W-1:0] fill_next;

   // Saturating count: once full, every accept yields a new window.
   assign fill_next    = (fill_p1 == FILL_FULL) ? FILL_FULL : fill_p1 + 1'b1;
   assign window_ready = accept && (fill_next == FILL_FULL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_p1 <= '0;
      end else if (flush) begin
         fill_p1 <= '0;
      end else if (accept) begin
         fill_p1 <= fill_next;
      end
   end
`endif

   // Stage p1: shift register, window-valid flag and consumed-window counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) slot_p1[k] <= '0;
         win_valid_p1 <= 1'b0;
         cnt_p1       <= '0;
      end else if (flush) begin
         for (int k = 0; k < TAPS; k++) slot_p1[k] <= '0;
         win_valid_p1 <= 1'b0;
         cnt_p1       <= '0;
      end else begin
         if (accept) begin
            for (int k = TAPS - 1; k > 0; k--) slot_p1[k] <= slot_p1[k-1];
            slot_p1[0] <= bus.in_data;
         end
         if (consume) cnt_p1 <= cnt_p1 + 1'b1;
         if (window_ready)       win_valid_p1 <= 1'b1;
         else if (bus.win_ready) win_valid_p1 <= 1'b0;
      end
   end

   for (genvar k = 0; k < TAPS; k++) begin : g_pack
      assign bus.win_data[k*WIDTH +: WIDTH] = slot_p1[k];
   end

   assign bus.win_valid = win_valid_p1;
   assign bus.win_cnt   = cnt_p1;
endmodule

// File: tb/tb_fir_tap_line.sv
// Directed bench for fir_tap_line: cycle table for fill/slide/stall/flush, plus async reset and counter wrap.
module tb_fir_tap_line;
   localparam int WIDTH = 16;
   localparam int TAPS  = 6;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   total = 0;
   int   passed = 0;

   fir_tap_line_if #(.WIDTH(WIDTH), .TAPS(TAPS), .CNT_W(CNT_W)) bus ();

   fir_tap_line #(.WIDTH(WIDTH), .TAPS(TAPS), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [15:0] d;
      logic        wr;
      logic        e_ir;
      logic        e_wv;
      logic [95:0] e_wd;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t vt[21];

   function automatic logic [95:0] w(input logic [15:0] s0, s1, s2, s3, s4, s5);
      return {s5, s4, s3, s2, s1, s0};
   endfunction

   function automatic vec_t mk(input logic fl, iv, input logic [15:0] d, input logic wr,
                               input logic e_ir, e_wv, input logic [95:0] e_wd,
                               input logic [3:0] e_cnt);
      vec_t v;
      v.fl = fl; v.iv = iv; v.d = d; v.wr = wr;
      v.e_ir = e_ir; v.e_wv = e_wv; v.e_wd = e_wd; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive(input logic fl, iv, input logic [15:0] d, input logic wr);
      flush = fl;
      bus.in_valid = iv;
      bus.in_data = d;
      bus.win_ready = wr;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", {95'b0, bus.in_ready}, 96'd0);
      chk("reset win_valid", {95'b0, bus.win_valid}, 96'd0);
      chk("reset win_data", bus.win_data, 96'd0);
      chk("reset win_cnt", {92'b0, bus.win_cnt}, 96'd0);
      rst = 1'b0;

`ifdef FIR_TAP_ZERO_PRIME_EN
      drive(1'b0, 1'b1, 16'h0005, 1'b0);
      @(negedge clk);
      chk("prime first in_ready", {95'b0, bus.in_ready}, 96'd1);
      chk("prime pre win_valid", {95'b0, bus.win_valid}, 96'd0);
      next_cycle();
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      @(negedge clk);
      chk("prime win_valid", {95'b0, bus.win_valid}, 96'd1);
      chk("prime win_data", bus.win_data, w(16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0));
      chk("prime win_cnt", {92'b0, bus.win_cnt}, 96'd0);
      next_cycle();
`else
      // Fill 1..6, slide to 7, stall three cycles, release with 8, flush, refill 10..15.
      vt[0]  = mk(0, 1, 16'd1,  1, 1, 0, 96'd0, 4'd0);
      vt[1]  = mk(0, 1, 16'd2,  1, 1, 0, w(1, 0, 0, 0, 0, 0), 4'd0);
      vt[2]  = mk(0, 1, 16'd3,  1, 1, 0, w(2, 1, 0, 0, 0, 0), 4'd0);
      vt[3]  = mk(0, 1, 16'd4,  1, 1, 0, w(3, 2, 1, 0, 0, 0), 4'd0);
      vt[4]  = mk(0, 1, 16'd5,  1, 1, 0, w(4, 3, 2, 1, 0, 0), 4'd0);
      vt[5]  = mk(0, 1, 16'd6,  1, 1, 0, w(5, 4, 3, 2, 1, 0), 4'd0);
      vt[6]  = mk(0, 1, 16'd7,  1, 1, 1, w(6, 5, 4, 3, 2, 1), 4'd0);
      vt[7]  = mk(0, 1, 16'd8,  0, 0, 1, w(7, 6, 5, 4, 3, 2), 4'd1);
      vt[8]  = mk(0, 1, 16'd8,  0, 0, 1, w(7, 6, 5, 4, 3, 2), 4'd1);
      vt[9]  = mk(0, 1, 16'd8,  0, 0, 1, w(7, 6, 5, 4, 3, 2), 4'd1);
      vt[10] = mk(0, 1, 16'd8,  1, 1, 1, w(7, 6, 5, 4, 3, 2), 4'd1);
      vt[11] = mk(0, 0, 16'd0,  0, 0, 1, w(8, 7, 6, 5, 4, 3), 4'd2);
      vt[12] = mk(1, 1, 16'd9,  1, 0, 1, w(8, 7, 6, 5, 4, 3), 4'd2);
      vt[13] = mk(0, 1, 16'd10, 1, 1, 0, 96'd0, 4'd0);
      vt[14] = mk(0, 1, 16'd11, 1, 1, 0, w(10, 0, 0, 0, 0, 0), 4'd0);
      vt[15] = mk(0, 1, 16'd12, 1, 1, 0, w(11, 10, 0, 0, 0, 0), 4'd0);
      vt[16] = mk(0, 1, 16'd13, 1, 1, 0, w(12, 11, 10, 0, 0, 0), 4'd0);
      vt[17] = mk(0, 1, 16'd14, 1, 1, 0, w(13, 12, 11, 10, 0, 0), 4'd0);
      vt[18] = mk(0, 1, 16'd15, 1, 1, 0, w(14, 13, 12, 11, 10, 0), 4'd0);
      vt[19] = mk(0, 0, 16'd0,  1, 1, 1, w(15, 14, 13, 12, 11, 10), 4'd0);
      vt[20] = mk(0, 0, 16'd0,  0, 1, 0, w(15, 14, 13, 12, 11, 10), 4'd1);

      for (int i = 0; i < 21; i++) begin
         drive(vt[i].fl, vt[i].iv, vt[i].d, vt[i].wr);
         @(negedge clk);
         chk($sformatf("vec%0d in_ready", i), {95'b0, bus.in_ready}, {95'b0, vt[i].e_ir});
         chk($sformatf("vec%0d win_valid", i), {95'b0, bus.win_valid}, {95'b0, vt[i].e_wv});
         chk($sformatf("vec%0d win_data", i), bus.win_data, vt[i].e_wd);
         chk($sformatf("vec%0d win_cnt", i), {92'b0, bus.win_cnt}, {92'b0, vt[i].e_cnt});
         next_cycle();
      end

      // Four more samples, then reset between edges must clear outputs without a clock.
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 16'(16'h20 + i), 1'b1);
         next_cycle();
      end
      #2;
      rst = 1'b1;
      #1;
      chk("async rst in_ready", {95'b0, bus.in_ready}, 96'd0);
      chk("async rst win_valid", {95'b0, bus.win_valid}, 96'd0);
      chk("async rst win_data", bus.win_data, 96'd0);
      chk("async rst win_cnt", {92'b0, bus.win_cnt}, 96'd0);
      next_cycle();
      rst = 1'b0;

      begin
         logic [15:0] samp [6];
         samp[0] = 16'h8000; samp[1] = 16'h7FFF; samp[2] = 16'h0001;
         samp[3] = 16'hFFFF; samp[4] = 16'h1234; samp[5] = 16'hEDCB;
         for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, samp[i], 1'b1);
            @(negedge clk);
            chk($sformatf("refill%0d win_valid", i), {95'b0, bus.win_valid}, 96'd0);
            next_cycle();
         end
         drive(1'b0, 1'b0, 16'h0, 1'b0);
         @(negedge clk);
         chk("bitexact win_valid", {95'b0, bus.win_valid}, 96'd1);
         chk("bitexact win_data", bus.win_data,
             w(16'hEDCB, 16'h1234, 16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000));
         next_cycle();
      end
`endif

      // Sixteen back-to-back consumed windows must wrap the 4-bit counter to zero.
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, 16'(16'h40 + i), 1'b1);
         next_cycle();
         if (i == 14) chk("wrap cnt 15", {92'b0, bus.win_cnt}, 96'd15);
      end
      chk("wrap cnt 0", {92'b0, bus.win_cnt}, 96'd0);
      chk("wrap win_valid", {95'b0, bus.win_valid}, 96'd1);
      drive(1'b0, 1'b0, 16'h0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
